// File: rtl/jk_program_counter.sv
// ---------------------------------------------------------------------------
// jk_program_counter
//
// Parametrised counter that behaves like a bank of WIDTH JK stages in toggle
// configuration. Used as the SAP program counter (CP = count, EP = bus enable,
// LP = load) and as the base of the controller's ring/step counter.
//
// The state register updates on the falling edge of CLK_N, the same edge the
// discrete JK stages use. CLR_N clears the count asynchronously and holds it
// at zero for as long as it is low.
//
// Parameters
//   WIDTH    : counter width in bits (1..16)
//   MODULUS  : count range is 0..MODULUS-1 (2..2**WIDTH)
//   SATURATE : 0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   CLK_N    in   1      inverted system clock, state moves on its falling edge
//   CLR_N    in   1      asynchronous active-low clear
//   CP       in   1      count enable
//   UP       in   1      direction, 1 = increment, 0 = decrement
//   LP       in   1      parallel load enable (wins over CP)
//   D        in   WIDTH  parallel load value, loaded verbatim
//   EP       in   1      bus output enable
//   Q        out  WIDTH  current count, always driven
//   BUS_OUT  out  WIDTH  Q when EP = 1, high impedance when EP = 0
//   TC       out  1      terminal count, combinational, for cascading
// ---------------------------------------------------------------------------
module jk_program_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter int SATURATE = 0
) (
    input  logic             CLK_N,
    input  logic             CLR_N,
    input  logic             CP,
    input  logic             UP,
    input  logic             LP,
    input  logic [WIDTH-1:0] D,
    input  logic             EP,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] BUS_OUT,
    output logic             TC
);

    // Largest legal count. MODULUS may be 2**WIDTH, so the subtraction is
    // done in integer arithmetic before narrowing to the counter width.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic             SAT_EN  = (SATURATE != 0);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_next;
    logic             at_top;
    logic             at_bottom;

    // ">=" rather than "==" so an out-of-range loaded value still wraps (or
    // holds) on the next up count instead of running through the spare codes.
    assign at_top    = (count_q >= MAX_VAL);
    assign at_bottom = (count_q == '0);

    // Next-state selection: LP > CP > hold. Every wrap is explicit, so the
    // WIDTH-bit increment/decrement never relies on natural overflow.
    always_comb begin
        count_next = count_q;
        if (LP) begin
            count_next = D;
        end else if (CP) begin
            if (UP) begin
                if (!at_top) begin
                    count_next = count_q + WIDTH'(1);
                end else if (!SAT_EN) begin
                    count_next = '0;
                end
            end else begin
                if (!at_bottom) begin
                    count_next = count_q - WIDTH'(1);
                end else if (!SAT_EN) begin
                    count_next = MAX_VAL;
                end
            end
        end
    end

    always_ff @(negedge CLK_N or negedge CLR_N) begin
        if (!CLR_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

    assign Q = count_q;

    // TC is deliberately not masked by LP: it is the enable for the next
    // cascaded stage on the same edge and depends only on CP, UP and Q.
    assign TC = CP & (UP ? at_top : at_bottom);

    assign BUS_OUT = EP ? count_q : {WIDTH{1'bz}};

endmodule

// File: doc/jk_program_counter.md
Name: jk_program_counter

Overview:
- Parametrised synchronous counter. Behaves as a bank of WIDTH JK stages in toggle configuration.
- Successor to the single JK flip-flop. Generalised to N bits, with up/down, parallel load, modulus, saturation, terminal count and bus output enable.
- Serves as the SAP program counter (CP/EP/LP roles). Also used as the ring/step counter base in the controller.
- Drives the shared W bus through a tri-state output.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..16.
- MODULUS, 2**WIDTH, count range is 0..MODULUS-1; legal range 2..2**WIDTH.
- SATURATE, 0; 0 = wrap at the range ends, 1 = hold at the range ends.

Ports:
- CLK_N  input  1  inverted system clock; state updates on the falling edge of CLK_N, same edge as the JK stages.
- CLR_N  input  1  asynchronous active-low clear.
- CP  input  1  count enable.
- UP  input  1  direction: 1 = increment, 0 = decrement; sampled only when counting.
- LP  input  1  parallel load enable.
- D  input  WIDTH  parallel load value.
- EP  input  1  bus output enable.
- Q  output  WIDTH  current count, always driven.
- BUS_OUT  output  WIDTH  equals Q when EP=1, all 'z' when EP=0.
- TC  output  1  terminal count flag.

Behaviour:
- Clock and reset: one clock (CLK_N); reset is asynchronous and active-low (CLR_N).
- CLR_N=0 forces Q=0 immediately, regardless of clock. All clock edges are ignored while CLR_N is low.
  - TC follows its combinational definition (TC=1 only if CP=1, UP=0 and Q=0).
  - BUS_OUT follows EP.
- After CLR_N rises, the first falling CLK_N edge operates normally. Release is assumed synchronous to CLK_N high.
- Clear asserted mid-sequence discards the count. No partial update is allowed.
- Sampled priority on each falling CLK_N edge: CLR_N > LP > CP > hold.
- LP=1: Q <= D, regardless of CP/UP. D is loaded verbatim, even if D >= MODULUS.
- LP=0, CP=1, UP=1:
  - Q < MODULUS-1: Q <= Q+1.
  - Q >= MODULUS-1: Q <= 0 if SATURATE=0; Q holds if SATURATE=1.
- LP=0, CP=1, UP=0:
  - Q = 0: Q <= MODULUS-1 if SATURATE=0; Q holds if SATURATE=1.
  - Q > 0: Q <= Q-1. A loaded out-of-range value counts down normally.
- LP=0, CP=0: Q holds.
- Latency: Q reflects load/count one edge after sampling. There is no pipelining.
- TC is combinational:
  - UP=1: TC = CP & (Q >= MODULUS-1).
  - UP=0: TC = CP & (Q == 0).
  - LP does not mask TC.
  - TC is intended as the enable for cascading the next counter stage on the same edge.
- BUS_OUT is combinational from EP and Q; there is no registered delay. EP has no effect on counting.
- The arithmetic is WIDTH bits wide. There is no intermediate overflow, because the wrap is explicit.
- Inputs must be stable from the rising CLK_N edge to the falling CLK_N edge (master window).

Test Plan:
- Reset: drive CLR_N=0 with CP=1 and toggle CLK_N. Required: Q=0, TC=0, BUS_OUT=z (EP=0). Then release, CP=1, UP=1, 3 edges. Required: Q=1,2,3.
- Wrap up: WIDTH=4, MODULUS=10, SATURATE=0, load D=8, CP=1, UP=1. Required: Q=8,9,0,1; TC=1 only while Q=9.
- Wrap down, plus saturate variant:
  - From Q=1, UP=0, 3 edges. Required: Q=0,9,8; TC=1 while Q=0.
  - Repeat with SATURATE=1. Required: Q=0,0,0.
- Priority and load: Q=5, LP=1, CP=1, D=12. Required: Q=12.
  - Then LP=0, UP=1, MODULUS=10. Required: next Q=0.
  - With UP=0 instead. Required: Q=11.
- Async clear mid-count: Q=7, counting. Assert CLR_N low for 3 ns while CLK_N is high. Required: Q=0 immediately, with no CLK_N edge needed. Next edge after release gives Q=1.
- Bus: Q=6, EP=1. Required: BUS_OUT=6. Set EP=0. Required: BUS_OUT=zzzz, while Q keeps counting to 7.
